// File: rtl/umni_pkg.sv
// ============================================================================
// Module      : umni_pkg
// Description : Shared state encodings and BCD limits for the countdown block
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package umni_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

    // One BCD digit decremented with borrow-out; wraps 0 to the given max.
    function automatic logic [4:0] bcd_digit_dec(input logic [3:0] dig, input logic [3:0] max);
        if (dig == 4'd0) begin
            return {1'b1, max};
        end
        return {1'b0, dig - 4'd1};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mmss_dec.sv
// ============================================================================
// Module      : bcd_mmss_dec
// Description : Combinational MM:SS BCD decrement, 00:01/00:00 flags, load check
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mmss_dec
    import umni_pkg::*;
(
    input  logic [7:0] min_i,
    input  logic [7:0] sec_i,
    input  logic [7:0] ld_min_i,
    input  logic [7:0] ld_sec_i,
    output logic [7:0] min_o,
    output logic [7:0] sec_o,
    output logic       is_one_o,
    output logic       is_zero_o,
    output logic       ld_valid_o
);

    logic [4:0] w_sec_ones;
    logic [4:0] w_sec_tens;
    logic [4:0] w_min_ones;
    logic [3:0] w_min_tens;

    always_comb begin
        w_sec_ones = bcd_digit_dec(sec_i[3:0], BCD_DIGIT_MAX);
        w_sec_tens = {1'b0, sec_i[7:4]};
        w_min_ones = {1'b0, min_i[3:0]};
        w_min_tens = min_i[7:4];
        if (w_sec_ones[4]) begin
            w_sec_tens = bcd_digit_dec(sec_i[7:4], SEC_TENS_MAX);
        end
        if (w_sec_tens[4]) begin
            w_min_ones = bcd_digit_dec(min_i[3:0], BCD_DIGIT_MAX);
        end
        if (w_min_ones[4]) begin
            w_min_tens = min_i[7:4] - 4'd1;
        end
    end

    assign is_zero_o = (min_i == 8'h00) && (sec_i == 8'h00);
    assign is_one_o  = (min_i == 8'h00) && (sec_i == 8'h01);

    // Saturate at 00:00 so the count can never wrap.
    assign min_o = is_zero_o ? 8'h00 : {w_min_tens, w_min_ones[3:0]};
    assign sec_o = is_zero_o ? 8'h00 : {w_sec_tens[3:0], w_sec_ones[3:0]};

    assign ld_valid_o = (ld_min_i[7:4] <= BCD_DIGIT_MAX) && (ld_min_i[3:0] <= BCD_DIGIT_MAX) &&
                        (ld_sec_i[7:4] <= SEC_TENS_MAX)  && (ld_sec_i[3:0] <= BCD_DIGIT_MAX);

endmodule

`default_nettype wire

// File: rtl/countdown_mmss.sv
// ============================================================================
// Module      : countdown_mmss
// Description : Loadable BCD MM:SS countdown with start/pause/cancel and alarm
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_mmss
    import umni_pkg::*;
#(
    parameter int ALARM_SECS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    output logic [7:0] min_out,
    output logic [7:0] sec_out,
    output logic [1:0] state_out,
    output logic       running,
    output logic       alarm,
    output logic       done,
    output logic       load_err
);

    localparam int              CNT_W      = $clog2(ALARM_SECS + 1);
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_SECS - 1);

    state_t           state_q;
    logic [7:0]       cnt_min_q;
    logic [7:0]       cnt_sec_q;
    logic [CNT_W-1:0] alarm_cnt_q;
    logic             sec_tick_q;
    logic             running_q;
    logic             alarm_q;
    logic             done_q;
    logic             load_err_q;

    logic             w_tick;
    logic [7:0]       w_dec_min;
    logic [7:0]       w_dec_sec;
    logic             w_is_one;
    logic             w_is_zero;
    logic             w_ld_valid;

    assign w_tick = sec_tick & ~sec_tick_q;

    bcd_mmss_dec u_dec (
        .min_i      (cnt_min_q),
        .sec_i      (cnt_sec_q),
        .ld_min_i   (load_min),
        .ld_sec_i   (load_sec),
        .min_o      (w_dec_min),
        .sec_o      (w_dec_sec),
        .is_one_o   (w_is_one),
        .is_zero_o  (w_is_zero),
        .ld_valid_o (w_ld_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_min_q   <= 8'h00;
            cnt_sec_q   <= 8'h00;
            alarm_cnt_q <= '0;
            sec_tick_q  <= 1'b1;
            running_q   <= 1'b0;
            alarm_q     <= 1'b0;
            done_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sec_tick_q <= sec_tick;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (cancel) begin
                state_q     <= ST_IDLE;
                running_q   <= 1'b0;
                alarm_q     <= 1'b0;
                cnt_min_q   <= 8'h00;
                cnt_sec_q   <= 8'h00;
                alarm_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // A held pause outranks start and load even though it has no effect here.
                        if (!pause) begin
                            if (start) begin
                                if (!w_is_zero) begin
                                    state_q   <= ST_RUN;
                                    running_q <= 1'b1;
                                end
                            end else if (load) begin
                                if (w_ld_valid) begin
                                    cnt_min_q <= load_min;
                                    cnt_sec_q <= load_sec;
                                end else begin
                                    load_err_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_tick && w_is_one) begin
                            cnt_min_q   <= w_dec_min;
                            cnt_sec_q   <= w_dec_sec;
                            state_q     <= ST_ALARM;
                            running_q   <= 1'b0;
                            alarm_q     <= 1'b1;
                            done_q      <= 1'b1;
                            alarm_cnt_q <= '0;
                        end else begin
                            if (w_tick) begin
                                cnt_min_q <= w_dec_min;
                                cnt_sec_q <= w_dec_sec;
                            end
                            if (pause) begin
                                state_q   <= ST_PAUSE;
                                running_q <= 1'b0;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause) begin
                            if (start) begin
                                state_q   <= ST_RUN;
                                running_q <= 1'b1;
                            end else if (load) begin
                                if (w_ld_valid) begin
                                    cnt_min_q <= load_min;
                                    cnt_sec_q <= load_sec;
                                end else begin
                                    load_err_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_ALARM: begin
                        if (start) begin
                            state_q     <= ST_IDLE;
                            alarm_q     <= 1'b0;
                            alarm_cnt_q <= '0;
                        end else if (w_tick) begin
                            if (alarm_cnt_q == ALARM_LAST) begin
                                state_q     <= ST_IDLE;
                                alarm_q     <= 1'b0;
                                alarm_cnt_q <= '0;
                            end else begin
                                alarm_cnt_q <= alarm_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        alarm_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign min_out   = cnt_min_q;
    assign sec_out   = cnt_sec_q;
    assign state_out = state_q;
    assign running   = running_q;
    assign alarm     = alarm_q;
    assign done      = done_q;
    assign load_err  = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_countdown_mmss.sv
// ============================================================================
// Module      : tb_countdown_mmss
// Description : Directed self-checking bench for the MM:SS countdown
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_countdown_mmss;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic       cancel;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic [1:0] state_out;
    logic       running;
    logic       alarm;
    logic       done;
    logic       load_err;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int base;

    countdown_mmss #(.ALARM_SECS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_tick  (sec_tick),
        .load      (load),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .start     (start),
        .pause     (pause),
        .cancel    (cancel),
        .min_out   (min_out),
        .sec_out   (sec_out),
        .state_out (state_out),
        .running   (running),
        .alarm     (alarm),
        .done      (done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Count cycles each pulse output is high, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) done_cnt++;
        if (load_err === 1'b1) err_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic second();
        sec_tick = 1'b1;
        cyc(4);
        sec_tick = 1'b0;
        cyc(4);
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        load_min = m;
        load_sec = s;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic ctl(input logic s, input logic p, input logic c);
        start  = s;
        pause  = p;
        cancel = c;
        cyc(1);
        start  = 1'b0;
        pause  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        checks++;
        if ({min_out, sec_out, state_out, running, alarm, done, load_err} !== 22'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h",
                     {min_out, sec_out, state_out, running, alarm, done, load_err}, 22'd0);
        end
    endtask

    task automatic test_countdown();
        do_load(8'h00, 8'h03);
        ctl(1'b1, 1'b0, 1'b0);
        checks++;
        if ({min_out, sec_out, state_out, running} !== {8'h00, 8'h03, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL start_0003: got %h expected %h", {min_out, sec_out, state_out, running},
                     {8'h00, 8'h03, 2'd1, 1'b1});
        end
        base = done_cnt;
        second();
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h02, 2'd1}) begin
            errors++;
            $display("FAIL dec_0002: got %h expected %h", {min_out, sec_out, state_out}, {8'h00, 8'h02, 2'd1});
        end
        second();
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h01, 2'd1}) begin
            errors++;
            $display("FAIL dec_0001: got %h expected %h", {min_out, sec_out, state_out}, {8'h00, 8'h01, 2'd1});
        end
        second();
        checks++;
        if ({min_out, sec_out, state_out, alarm, running} !== {8'h00, 8'h00, 2'd3, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL expire_alarm: got %h expected %h", {min_out, sec_out, state_out, alarm, running},
                     {8'h00, 8'h00, 2'd3, 1'b1, 1'b0});
        end
        checks++;
        if (done_cnt - base !== 1) begin
            errors++;
            $display("FAIL done_pulse: got %0d cycles expected %0d", done_cnt - base, 1);
        end
        second();
        second();
        checks++;
        if ({state_out, alarm} !== {2'd3, 1'b1}) begin
            errors++;
            $display("FAIL alarm_hold: got %h expected %h", {state_out, alarm}, {2'd3, 1'b1});
        end
        second();
        checks++;
        if ({min_out, sec_out, state_out, alarm} !== {8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL alarm_return: got %h expected %h", {min_out, sec_out, state_out, alarm},
                     {8'h00, 8'h00, 2'd0, 1'b0});
        end
    endtask

    task automatic test_borrow();
        do_load(8'h10, 8'h00);
        ctl(1'b1, 1'b0, 1'b0);
        second();
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h09, 8'h59, 2'd1}) begin
            errors++;
            $display("FAIL borrow_1000: got %h expected %h", {min_out, sec_out, state_out}, {8'h09, 8'h59, 2'd1});
        end
        ctl(1'b0, 1'b1, 1'b0);
        do_load(8'h01, 8'h00);
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h01, 8'h00, 2'd2}) begin
            errors++;
            $display("FAIL pause_load: got %h expected %h", {min_out, sec_out, state_out}, {8'h01, 8'h00, 2'd2});
        end
        ctl(1'b1, 1'b0, 1'b0);
        second();
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h59, 2'd1}) begin
            errors++;
            $display("FAIL borrow_0100: got %h expected %h", {min_out, sec_out, state_out}, {8'h00, 8'h59, 2'd1});
        end
        ctl(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause_resume();
        do_load(8'h05, 8'h30);
        ctl(1'b1, 1'b0, 1'b0);
        ctl(1'b0, 1'b1, 1'b0);
        repeat (5) second();
        checks++;
        if ({min_out, sec_out, state_out, running} !== {8'h05, 8'h30, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL pause_hold: got %h expected %h", {min_out, sec_out, state_out, running},
                     {8'h05, 8'h30, 2'd2, 1'b0});
        end
        ctl(1'b1, 1'b0, 1'b0);
        second();
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h05, 8'h29, 2'd1}) begin
            errors++;
            $display("FAIL resume_dec: got %h expected %h", {min_out, sec_out, state_out}, {8'h05, 8'h29, 2'd1});
        end
        ctl(1'b0, 1'b0, 1'b1);
        checks++;
        if ({min_out, sec_out, state_out, running} !== {8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL cancel_run: got %h expected %h", {min_out, sec_out, state_out, running},
                     {8'h00, 8'h00, 2'd0, 1'b0});
        end
    endtask

    task automatic test_load_err();
        do_load(8'h12, 8'h34);
        base = err_cnt;
        do_load(8'h1A, 8'h00);
        checks++;
        if ({min_out, sec_out} !== {8'h12, 8'h34} || err_cnt - base !== 1) begin
            errors++;
            $display("FAIL bad_min_digit: got %h err %0d expected %h err 1", {min_out, sec_out},
                     err_cnt - base, {8'h12, 8'h34});
        end
        do_load(8'h00, 8'h60);
        checks++;
        if ({min_out, sec_out} !== {8'h12, 8'h34} || err_cnt - base !== 2) begin
            errors++;
            $display("FAIL bad_sec_tens: got %h err %0d expected %h err 2", {min_out, sec_out},
                     err_cnt - base, {8'h12, 8'h34});
        end
        ctl(1'b0, 1'b0, 1'b1);
        ctl(1'b1, 1'b0, 1'b0);
        checks++;
        if ({min_out, sec_out, state_out, running} !== {8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL start_at_zero: got %h expected %h", {min_out, sec_out, state_out, running},
                     {8'h00, 8'h00, 2'd0, 1'b0});
        end
    endtask

    task automatic test_pause_on_tick();
        do_load(8'h00, 8'h10);
        ctl(1'b1, 1'b0, 1'b0);
        sec_tick = 1'b1;
        pause    = 1'b1;
        cyc(1);
        pause    = 1'b0;
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h09, 2'd2}) begin
            errors++;
            $display("FAIL tick_pause: got %h expected %h", {min_out, sec_out, state_out}, {8'h00, 8'h09, 2'd2});
        end
        cyc(3);
        sec_tick = 1'b0;
        cyc(4);
        second();
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h09, 2'd2}) begin
            errors++;
            $display("FAIL pause_ignores_tick: got %h expected %h", {min_out, sec_out, state_out},
                     {8'h00, 8'h09, 2'd2});
        end
        base = err_cnt;
        do_load(8'h00, 8'h00);
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h00, 2'd2} || err_cnt != base) begin
            errors++;
            $display("FAIL pause_load_zero: got %h err %0d expected %h err 0", {min_out, sec_out, state_out},
                     err_cnt - base, {8'h00, 8'h00, 2'd2});
        end
        ctl(1'b1, 1'b0, 1'b1);
        checks++;
        if ({min_out, sec_out, state_out, running} !== {8'h00, 8'h00, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL cancel_beats_start: got %h expected %h", {min_out, sec_out, state_out, running},
                     {8'h00, 8'h00, 2'd0, 1'b0});
        end
    endtask

    task automatic test_reset_tick_high();
        sec_tick = 1'b1;
        reset    = 1'b1;
        cyc(2);
        reset    = 1'b0;
        do_load(8'h00, 8'h05);
        ctl(1'b1, 1'b0, 1'b0);
        cyc(3);
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h05, 2'd1}) begin
            errors++;
            $display("FAIL no_tick_after_reset: got %h expected %h", {min_out, sec_out, state_out},
                     {8'h00, 8'h05, 2'd1});
        end
        sec_tick = 1'b0;
        cyc(4);
        second();
        checks++;
        if ({min_out, sec_out, state_out} !== {8'h00, 8'h04, 2'd1}) begin
            errors++;
            $display("FAIL first_true_edge: got %h expected %h", {min_out, sec_out, state_out},
                     {8'h00, 8'h04, 2'd1});
        end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++;
        if ({min_out, sec_out, state_out, running, alarm, done, load_err} !== 22'd0) begin
            errors++;
            $display("FAIL reset_mid_run: got %h expected %h",
                     {min_out, sec_out, state_out, running, alarm, done, load_err}, 22'd0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        sec_tick = 1'b0;
        load     = 1'b0;
        load_min = 8'h00;
        load_sec = 8'h00;
        start    = 1'b0;
        pause    = 1'b0;
        cancel   = 1'b0;
        cyc(1);
        test_reset();
        test_countdown();
        test_borrow();
        test_pause_resume();
        test_load_err();
        test_pause_on_tick();
        test_reset_tick_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
